// File: rtl/axil_cmd_master.sv
// axil_cmd_master: single-outstanding AXI4-Lite master for register commands.
// Optional watchdog enabled by defining AXIL_MASTER_TIMEOUT_EN.
`ifndef CGRA_AXI_ADDR_WIDTH
`define CGRA_AXI_ADDR_WIDTH 13
`endif
`ifndef CGRA_AXI_DATA_WIDTH
`define CGRA_AXI_DATA_WIDTH 32
`endif

module axil_cmd_master #(
  parameter int ADDR_WIDTH     = `CGRA_AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH     = `CGRA_AXI_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  timeout_flag
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_e;

  state_e state_q, state_d;

  logic cmd_ready_q, cmd_ready_d;
  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic bready_q, bready_d;
  logic arvalid_q, arvalid_d;
  logic rready_q, rready_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_write_q, rsp_write_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;

  // Next-state and next-output decode; every handshake output is a flop.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          if (cmd_write) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        awvalid_d = awvalid_q & ~awready;
        wvalid_d  = wvalid_q & ~wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (bvalid && bready_q) begin
          state_d     = RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = bresp;
        end
      end
      RD_ADDR: begin
        if (arready && arvalid_q) begin
          state_d   = RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_DATA: begin
        if (rvalid && rready_q) begin
          state_d     = RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = rdata;
          rsp_resp_d  = rresp;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and registered outputs; reset drops every valid/ready at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign awvalid   = awvalid_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign wdata     = wdata_q;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tmo_q, tmo_d;
  logic            busy, start;

  assign busy  = state_q inside {WR_REQ, WR_RESP, RD_ADDR, RD_DATA};
  assign start = (state_q == IDLE) && cmd_valid && cmd_ready_q;

  // Watchdog: saturating count per transaction, flag is sticky until reset.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (busy && cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
    tmo_d = tmo_q | (busy && cnt_d == CntMax);
  end

  // Watchdog registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout_flag = tmo_q;
`else
  // No watchdog in this build; the expression is constant 0.
  assign timeout_flag = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_axil_cmd_master.sv
// tb_axil_cmd_master: directed checks of axil_cmd_master
// against a small reactive AXI4-Lite slave.
module tb_axil_cmd_master;

  localparam int AW = 16;
  localparam int DW = 32;
`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam logic TMO_EXP = 1'b1;
`else
  localparam logic TMO_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready;
  logic [DW-1:0] wdata, rdata;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, arvalid, arready;
  logic          rvalid, rready, timeout_flag;

  axil_cmd_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .rready(rready), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // slave configuration
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
  logic [31:0] s_rdata = 32'h0;

  // slave state
  int   aw_seen, w_seen, ar_seen, r_wait;
  int   n_b = 0;
  logic aw_got, w_got, ar_got;
  logic aw_p, w_p, b_p, ar_p, r_p;

  always @(negedge clk) begin
    if (reset) begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      aw_seen = 0; w_seen = 0; ar_seen = 0; r_wait = 0;
      aw_got = 0; w_got = 0; ar_got = 0;
    end else begin
      if (awready && aw_p) aw_got = 1;
      if (wready && w_p) w_got = 1;
      if (bvalid && b_p) begin bvalid = 0; n_b++; end
      if (arready && ar_p) begin ar_got = 1; r_wait = 0; end
      if (rvalid && r_p) rvalid = 0;
      awready = awvalid && (aw_seen >= aw_dly);
      aw_seen = awvalid ? aw_seen + 1 : 0;
      wready  = wvalid && (w_seen >= w_dly);
      w_seen  = wvalid ? w_seen + 1 : 0;
      arready = arvalid && (ar_seen >= ar_dly);
      ar_seen = arvalid ? ar_seen + 1 : 0;
      if (!bvalid && aw_got && w_got) begin
        bvalid = 1; bresp = s_bresp;
        aw_got = 0; w_got = 0;
      end
      if (ar_got && !rvalid) begin
        if (r_wait >= r_dly) begin
          rvalid = 1; rdata = s_rdata; rresp = s_rresp;
          ar_got = 0;
        end else begin
          r_wait++;
        end
      end
    end
    aw_p = awvalid; w_p = wvalid; b_p = bready;
    ar_p = arvalid; r_p = rready;
  end

  // channel overlap monitor
  int ovl = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (((awvalid || wvalid) && arvalid) ||
          ((awvalid || wvalid || arvalid) && rsp_valid))
        ovl++;
    end
  end

  // per-command observations
  int          lat, aw_hi, w_hi, ar_hi, addr_bad, stab_bad;
  logic        r_write;
  logic [31:0] r_rdata;
  logic [1:0]  r_resp;

  task automatic do_cmd(input logic wr,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] d,
                        input int hold);
    int k;
    cmd_valid = 1; cmd_write = wr;
    cmd_addr = a; cmd_wdata = d;
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge clk); k++;
    end
    check("cmd_accept", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
    lat = 1; aw_hi = 0; w_hi = 0; ar_hi = 0; addr_bad = 0;
    while (!rsp_valid && lat < 64) begin
      if (awvalid) begin aw_hi++; if (awaddr !== a) addr_bad++; end
      if (wvalid) begin w_hi++; if (wdata !== d) addr_bad++; end
      if (arvalid) begin ar_hi++; if (araddr !== a) addr_bad++; end
      @(negedge clk); lat++;
    end
    check("rsp_seen", rsp_valid, 1);
    r_write = rsp_write; r_rdata = rsp_rdata; r_resp = rsp_resp;
    stab_bad = 0;
    repeat (hold) begin
      @(negedge clk);
      if (!rsp_valid ||
          {rsp_write, rsp_resp, rsp_rdata} !== {r_write, r_resp, r_rdata})
        stab_bad++;
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog");
    $fatal(1);
  end

  initial begin
    int nb0;
    reset = 1; cmd_valid = 0; cmd_write = 0;
    cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    check("rst_ctl", {cmd_ready, awvalid, wvalid, bready,
                      arvalid, rready, rsp_valid, timeout_flag}, 0);
    check("rst_rsp", {rsp_write, rsp_resp, rsp_rdata}, 0);
    reset = 0;
    @(negedge clk);
    check("rdy_after_rst", cmd_ready, 1);

    // zero-wait write
    cmd_valid = 1; cmd_write = 1;
    cmd_addr = 16'h0010; cmd_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("t1_aw_w", {awvalid, wvalid}, 2'b11);
    check("t1_awaddr", awaddr, 16'h0010);
    check("t1_wdata", wdata, 32'hDEADBEEF);
    check("t1_cmdrdy", cmd_ready, 0);
    cmd_valid = 0;
    @(negedge clk);
    check("t1_bready", {bready, awvalid, wvalid}, 3'b100);
    @(negedge clk);
    check("t1_rspv", rsp_valid, 1);
    check("t1_rsp", {rsp_write, rsp_resp, rsp_rdata}, {1'b1, 2'b00, 32'h0});
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check("t1_done", {rsp_valid, cmd_ready}, 2'b01);

    // write, awready delayed
    aw_dly = 4; s_bresp = 2'b11;
    nb0 = n_b;
    do_cmd(1'b1, 16'h0044, 32'hA5A50001, 0);
    check("t2_lat", lat, 7);
    check("t2_aw_hi", aw_hi, 5);
    check("t2_w_hi", w_hi, 1);
    check("t2_stable", addr_bad, 0);
    check("t2_rsp", {r_write, r_resp, r_rdata}, {1'b1, 2'b11, 32'h0});
    repeat (3) @(negedge clk);
    check("t2_one_b", n_b - nb0, 1);

    // read, data after idle cycles, response held
    aw_dly = 0; r_dly = 3;
    s_rdata = 32'h12345678; s_rresp = 2'b10;
    do_cmd(1'b0, 16'h0020, 32'h0, 5);
    check("t3_lat", lat, 6);
    check("t3_ar_hi", ar_hi, 1);
    check("t3_addr", addr_bad, 0);
    check("t3_rsp", {r_write, r_resp, r_rdata}, {1'b0, 2'b10, 32'h12345678});
    check("t3_hold", stab_bad, 0);

    // back-to-back write then read, cmd_valid held
    r_dly = 0; s_bresp = 2'b00;
    s_rdata = 32'hCAFE0001; s_rresp = 2'b00;
    cmd_valid = 1; cmd_write = 1;
    cmd_addr = 16'h0030; cmd_wdata = 32'h11112222;
    @(negedge clk);
    check("t4_aw", awvalid, 1);
    cmd_write = 0; cmd_addr = 16'h0034;
    @(negedge clk);
    @(negedge clk);
    check("t4_wrsp", {rsp_valid, rsp_write, cmd_ready}, 3'b110);
    @(negedge clk);
    check("t4_wait", {rsp_valid, cmd_ready, arvalid}, 3'b100);
    rsp_ready = 1;
    @(negedge clk);
    check("t4_rdy", {rsp_valid, cmd_ready, arvalid}, 3'b010);
    rsp_ready = 0;
    @(negedge clk);
    check("t4_ar", {arvalid, cmd_ready}, 2'b10);
    check("t4_araddr", araddr, 16'h0034);
    cmd_valid = 0;
    @(negedge clk);
    check("t4_rready", rready, 1);
    @(negedge clk);
    check("t4_rrsp", {rsp_valid, rsp_write, rsp_rdata},
          {1'b1, 1'b0, 32'hCAFE0001});
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;

    // reset while in RD_DATA
    r_dly = 10;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h0050;
    @(negedge clk);
    cmd_valid = 0;
    check("t5_ar", arvalid, 1);
    @(negedge clk);
    check("t5_rd_data", rready, 1);
    reset = 1;
    #1;
    check("t5_async", {arvalid, rready, rsp_valid, cmd_ready}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0; r_dly = 0;
    s_rdata = 32'h0BADF00D; s_rresp = 2'b01;
    @(negedge clk);
    do_cmd(1'b0, 16'h0058, 32'h0, 0);
    check("t5_lat", lat, 3);
    check("t5_rsp", {r_write, r_resp, r_rdata}, {1'b0, 2'b01, 32'h0BADF00D});

    // slave never raises arready
    ar_dly = 1000;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h0060;
    @(negedge clk);
    cmd_valid = 0;
    repeat (15) @(negedge clk);
    check("t6_pre", timeout_flag, 0);
    @(negedge clk);
    check("t6_flag", timeout_flag, TMO_EXP);
    repeat (5) @(negedge clk);
    check("t6_sticky", {timeout_flag, arvalid}, {TMO_EXP, 1'b1});
    reset = 1;
    @(negedge clk);
    check("t6_clr", timeout_flag, 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);

    check("overlap", ovl, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
